// File: rtl/rs232_pkg.sv
// Shared constants and state type for the RS232 Avalon-MM slave and its RSA wrapper.
package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;
  localparam int OVR_BIT   = 5;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } UartState;

  function automatic logic [31:0] status_word(input logic rx_ok, input logic tx_ok,
                                              input logic ovr);
    logic [31:0] w;
    w            = 32'd0;
    w[RX_OK_BIT] = rx_ok;
    w[TX_OK_BIT] = tx_ok;
    w[OVR_BIT]   = ovr;
    return w;
  endfunction

endpackage

// File: rtl/rs232_avm_slave_if.sv
// Avalon-MM bus bundle between the polling master and the RS232 slave.
interface rs232_avm_slave_if;

  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/rs232_rx_deser.sv
// 8N1 receiver: 2-FF synchroniser, start-bit glitch filter, framing check.
// Emits the received byte with a one-cycle valid pulse.
module rs232_rx_deser
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       valid_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  UartState      state_q;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          ferr_q;
  logic [7:0]    byte_q;
  logic          valid_q;
  logic          rxd_s;

  assign rxd_s   = sync_q[1];
  assign byte_o  = byte_q;
  assign valid_o = valid_q;

  // Synchroniser and receive state machine; ferr_q holds STOP until the line idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= U_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      ferr_q  <= 1'b0;
      byte_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      prev_q  <= rxd_s;
      valid_q <= 1'b0;
      case (state_q)
        U_IDLE: begin
          cnt_q  <= '0;
          idx_q  <= 3'd0;
          ferr_q <= 1'b0;
          if (prev_q && !rxd_s) begin
            state_q <= U_START;
          end
        end
        U_START: begin
          if (cnt_q == MID) begin
            cnt_q   <= '0;
            state_q <= rxd_s ? U_IDLE : U_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        U_DATA: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= U_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        U_STOP: begin
          if (ferr_q) begin
            if (rxd_s) begin
              state_q <= U_IDLE;
            end
          end else if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (rxd_s) begin
              byte_q  <= shift_q;
              valid_q <= 1'b1;
              state_q <= U_IDLE;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rs232_avm_slave.sv
// Avalon-MM slave with one wait state exposing an 8N1 UART as RX, TX and STATUS words.
// Holds the TX serialiser and register logic; reception is in rs232_rx_deser.
module rs232_avm_slave
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic               avm_clk,
  input  logic               avm_rst,
  rs232_avm_slave_if.slave   bus,
  input  logic               uart_rxd,
  output logic               uart_txd
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          ack_q;
  logic [31:0]   rdata_q;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_ok_q, rx_ok_d;
  logic          ovr_q, ovr_d;
  logic          tx_ok_q;
  UartState      tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_idx_q;
  logic [7:0]    tx_shift_q;
  logic          txd_q;

  logic          req_s, accept_s, rd_acc_s, wr_acc_s;
  logic          rx_clr_s, st_clr_s, tx_load_s, ovr_set_s;
  logic [31:0]   rdmux_s;
  logic [7:0]    rx_new_s;
  logic          rx_valid_s;
  logic          unused_wdata_hi;

  assign unused_wdata_hi     = ^bus.avm_writedata[31:8];
  assign bus.avm_waitrequest = req_s & ~ack_q;
  assign bus.avm_readdata    = rdata_q;
  assign uart_txd            = txd_q;

  rs232_rx_deser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk    (avm_clk),
    .rst_n  (avm_rst),
    .rxd_i  (uart_rxd),
    .byte_o (rx_new_s),
    .valid_o(rx_valid_s)
  );

  // Bus decode and flag next-state; a new byte or overrun beats a same-cycle clear.
  always_comb begin
    req_s     = bus.avm_read | bus.avm_write;
    accept_s  = req_s & ack_q;
    rd_acc_s  = accept_s & bus.avm_read;
    wr_acc_s  = accept_s & bus.avm_write & ~bus.avm_read;
    rx_clr_s  = rd_acc_s & (bus.avm_address == RX_BASE);
    st_clr_s  = rd_acc_s & (bus.avm_address == STATUS_BASE);
    tx_load_s = wr_acc_s & (bus.avm_address == TX_BASE) & tx_ok_q;
    ovr_set_s = rx_valid_s & rx_ok_q & ~rx_clr_s;

    case (bus.avm_address)
      RX_BASE:     rdmux_s = {24'd0, rx_byte_q};
      STATUS_BASE: rdmux_s = status_word(rx_ok_q, tx_ok_q, ovr_q);
      default:     rdmux_s = 32'd0;
    endcase

    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (st_clr_s) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end

    if (rx_valid_s && !ovr_set_s) begin
      rx_byte_d = rx_new_s;
    end else begin
      rx_byte_d = rx_byte_q;
    end

    if (rx_valid_s) begin
      rx_ok_d = 1'b1;
    end else if (rx_clr_s) begin
      rx_ok_d = 1'b0;
    end else begin
      rx_ok_d = rx_ok_q;
    end
  end

  // Wait-state generator, read data capture in the stall cycle, RX flags.
  always_ff @(posedge avm_clk or negedge avm_rst) begin
    if (!avm_rst) begin
      ack_q     <= 1'b0;
      rdata_q   <= 32'd0;
      rx_byte_q <= 8'd0;
      rx_ok_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ack_q <= req_s & ~ack_q;
      if (req_s && !ack_q && bus.avm_read) begin
        rdata_q <= rdmux_s;
      end
      rx_byte_q <= rx_byte_d;
      rx_ok_q   <= rx_ok_d;
      ovr_q     <= ovr_d;
    end
  end

  // Transmit state machine; txd comes straight from a flop.
  always_ff @(posedge avm_clk or negedge avm_rst) begin
    if (!avm_rst) begin
      tx_state_q <= U_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_ok_q    <= 1'b1;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        U_IDLE: begin
          txd_q <= 1'b1;
          if (tx_load_s) begin
            tx_shift_q <= bus.avm_writedata[7:0];
            tx_ok_q    <= 1'b0;
            txd_q      <= 1'b0;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_state_q <= U_START;
          end
        end
        U_START: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= U_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        U_DATA: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= U_STOP;
            end else begin
              tx_idx_q   <= tx_idx_q + 3'd1;
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        U_STOP: begin
          if (tx_cnt_q == LAST) begin
            tx_cnt_q   <= '0;
            tx_ok_q    <= 1'b1;
            tx_state_q <= U_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: begin
          tx_state_q <= U_IDLE;
          txd_q      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_avm_slave.sv
// Randomised bench for rs232_avm_slave with a frame-level reference model and literal spot checks.
module tb_rs232_avm_slave;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic txd;

  rs232_avm_slave_if bus ();

  rs232_avm_slave #(.CLKS_PER_BIT(CPB)) dut (
    .avm_clk (clk),
    .avm_rst (rst_n),
    .bus     (bus),
    .uart_rxd(rxd),
    .uart_txd(txd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  // Reference model state
  bit          tx_q[$];
  bit          m_rx_ok;
  bit          m_ovr;
  logic [7:0]  m_rx_byte;
  logic [31:0] m_rd;
  int          phase;
  typedef struct packed {logic [7:0] b; bit good;} rx_ev_t;
  rx_ev_t      rx_evq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_word(input logic [4:0] a, input bit tx_ok);
    case (a)
      5'd0:    return {24'd0, m_rx_byte};
      5'd8:    return {24'd0, m_rx_ok, tx_ok, m_ovr, 5'd0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic monitor();
    bit     tx_ok;
    bit     exp_txd;
    rx_ev_t ev;
    while (!done) begin
      @(negedge clk);
      if (!rst_n) begin
        tx_q.delete();
        rx_evq.delete();
        m_rx_ok = 1'b0; m_ovr = 1'b0; m_rx_byte = 8'd0; m_rd = 32'd0; phase = 0;
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_wait", {31'd0, bus.avm_waitrequest}, 32'd0);
        check("rst_rdata", bus.avm_readdata, 32'd0);
      end else begin
        tx_ok   = (tx_q.size() == 0);
        exp_txd = tx_ok ? 1'b1 : tx_q.pop_front();
        check("txd", {31'd0, txd}, {31'd0, exp_txd});
        while (rx_evq.size() > 0) begin
          ev = rx_evq.pop_front();
          if (ev.good) begin
            if (m_rx_ok) m_ovr = 1'b1;
            else begin m_rx_byte = ev.b; m_rx_ok = 1'b1; end
          end
        end
        check("rdata_hold", bus.avm_readdata, m_rd);
        if (bus.avm_read || bus.avm_write) begin
          if (phase == 0) begin
            check("wait_stall", {31'd0, bus.avm_waitrequest}, 32'd1);
            if (bus.avm_read) m_rd = m_word(bus.avm_address, tx_ok);
            phase = 1;
          end else begin
            check("wait_accept", {31'd0, bus.avm_waitrequest}, 32'd0);
            if (bus.avm_read) begin
              if (bus.avm_address == 5'd0) m_rx_ok = 1'b0;
              if (bus.avm_address == 5'd8) m_ovr = 1'b0;
            end else if (bus.avm_address == 5'd4 && tx_ok) begin
              for (int k = 0; k < CPB; k++) tx_q.push_back(1'b0);
              for (int i = 0; i < 8; i++)
                for (int k = 0; k < CPB; k++) tx_q.push_back(bus.avm_writedata[i]);
              for (int k = 0; k < CPB; k++) tx_q.push_back(1'b1);
            end
            phase = 0;
          end
        end else begin
          check("wait_idle", {31'd0, bus.avm_waitrequest}, 32'd0);
          phase = 0;
        end
      end
    end
  endtask

  task automatic bus_op(input bit rd, input bit wr, input logic [4:0] a,
                        input logic [31:0] wd, output logic [31:0] q);
    @(posedge clk); #1;
    bus.avm_address = a; bus.avm_read = rd; bus.avm_write = wr; bus.avm_writedata = wd;
    @(posedge clk);
    @(negedge clk);
    q = bus.avm_readdata;
    @(posedge clk); #1;
    bus.avm_read = 1'b0; bus.avm_write = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit good);
    logic [9:0] fr;
    rx_ev_t ev;
    fr = {good, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      rxd = fr[j];
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    rxd = 1'b1;
    repeat (10) @(posedge clk);
    ev.b = b; ev.good = good;
    rx_evq.push_back(ev);
  endtask

  task automatic stimulus();
    logic [31:0] q;
    logic [9:0]  a5_bits;
    logic [4:0]  addr_tab [5];
    int          op;
    addr_tab = '{5'd12, 5'd16, 5'd1, 5'd31, 5'd4};
    a5_bits  = 10'b1101001010;

    #23 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("reset_status", q, 32'h40);

    bus_op(1'b0, 1'b1, 5'd4, 32'hA5, q);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c % 4 == 1) check("tx_a5_bit", {31'd0, txd}, {31'd0, a5_bits[c / 4]});
    end
    repeat (3) @(posedge clk);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("status_after_a5", q, 32'h40);

    bus_op(1'b0, 1'b1, 5'd4, 32'h81, q);
    repeat (8) @(posedge clk);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("status_mid_frame", q, 32'h00);
    bus_op(1'b0, 1'b1, 5'd4, 32'h3C, q);
    repeat (50) @(posedge clk);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("status_after_drop", q, 32'h40);

    send_rx(8'h5A, 1'b1);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("status_rx_full", q, 32'hC0);
    bus_op(1'b1, 1'b0, 5'd0, 32'd0, q); check("rx_5a", q, 32'h5A);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("status_rx_read", q, 32'h40);

    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_op(1'b1, 1'b0, 5'd0, 32'd0, q); check("ovr_rx_11", q, 32'h11);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("status_ovr", q, 32'h60);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("status_ovr_clr", q, 32'h40);

    @(posedge clk); #1 rxd = 1'b0;
    @(posedge clk); #1 rxd = 1'b1;
    repeat (12) @(posedge clk);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("status_glitch", q, 32'h40);
    send_rx(8'h33, 1'b0);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("status_ferr", q, 32'h40);
    bus_op(1'b1, 1'b0, 5'd0, 32'd0, q); check("rx_after_ferr", q, 32'h11);

    bus_op(1'b0, 1'b1, 5'd4, 32'h77, q);
    repeat (13) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("mid_rst_txd", {31'd0, txd}, 32'd1);
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    bus_op(1'b1, 1'b0, 5'd8, 32'd0, q); check("status_after_rst", q, 32'h40);
    bus_op(1'b0, 1'b1, 5'd4, 32'h96, q);
    repeat (45) @(posedge clk);

    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: send_rx(8'($urandom), ($urandom_range(0, 4) != 0));
        1: bus_op(1'b1, 1'b0, 5'd8, 32'd0, q);
        2: bus_op(1'b1, 1'b0, 5'd0, 32'd0, q);
        3: bus_op(1'b0, 1'b1, 5'd4, $urandom, q);
        4: bus_op(1'b1, 1'b0, addr_tab[$urandom_range(0, 4)], 32'd0, q);
        5: bus_op(1'b1, 1'b1, 5'd4, $urandom, q);
        6: repeat ($urandom_range(1, 30)) @(posedge clk);
        default: bus_op(1'b0, 1'b1, ($urandom_range(0, 1) != 0) ? 5'd8 : 5'd0, $urandom, q);
      endcase
    end
    repeat (60) @(posedge clk);
    done = 1'b1;
  endtask

  initial begin
    bus.avm_address   = 5'd0;
    bus.avm_read      = 1'b0;
    bus.avm_write     = 1'b0;
    bus.avm_writedata = 32'd0;
    fork
      monitor();
      stimulus();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
